// File: rtl/serial_parity.sv
// serial_parity: accumulates FRAME_LEN serial data bits into an even-parity
// result and presents it with a valid/ready output handshake.
//
// Handshake rules (both sides):
//   - A bit is taken on a rising clk edge where in_valid && in_ready.
//     The producer may hold in_valid low at any point in a frame.
//   - A result is taken on a rising clk edge where out_valid && out_ready.
//     out_parity and err stay stable from out_valid rising until it is taken.
//
// Optional build macro SERIAL_PARITY_CHECK_EN: after the data bits, one extra
// received-parity bit is taken in a check state. err reports a mismatch
// between that bit and the computed parity. When the macro is undefined
// there is no check state and err is tied low.
//
// state_dbg exposes the FSM state: 0 idle, 1 acc, 2 chk, 3 done.
module serial_parity #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_parity,
    input  logic       out_ready,
    output logic       err,
    output logic [5:0] bit_cnt,
    output logic [1:0] state_dbg
);

    // Count value reached by the accept of the final data bit.
    localparam logic [5:0] last_cnt = 6'(FRAME_LEN);

`ifdef SERIAL_PARITY_CHECK_EN
    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_acc  = 2'd1,
        st_chk  = 2'd2,
        st_done = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_acc  = 2'd1,
        st_done = 2'd3
    } state_t;
`endif

    state_t     state;
    logic [5:0] cnt_q;
    logic       parity_q;
    logic       accept;
    logic [5:0] cnt_inc;

`ifdef SERIAL_PARITY_CHECK_EN
    logic       err_q;
`endif

    // Bits are only refused while a finished result waits to be taken.
    assign in_ready   = (state != st_done);
    assign accept     = in_valid && in_ready;
    assign cnt_inc    = cnt_q + 6'd1;

    // All outputs come straight from registers; nothing combinational from in_bit.
    assign out_valid  = (state == st_done);
    assign out_parity = parity_q;
    assign bit_cnt    = cnt_q;
    assign state_dbg  = state;

`ifdef SERIAL_PARITY_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Frame FSM: clear outranks everything, bubbles leave all state untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= st_idle;
            cnt_q    <= 6'd0;
            parity_q <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else if (clear) begin
            state    <= st_idle;
            cnt_q    <= 6'd0;
            parity_q <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                st_idle: begin
                    if (accept) begin
                        // First bit of a frame seeds the parity register.
                        parity_q <= in_bit;
                        cnt_q    <= 6'd1;
                        state    <= st_acc;
                    end
                end
                st_acc: begin
                    if (accept) begin
                        parity_q <= parity_q ^ in_bit;
                        cnt_q    <= cnt_inc;
                        if (cnt_inc == last_cnt) begin
`ifdef SERIAL_PARITY_CHECK_EN
                            state <= st_chk;
`else
                            state <= st_done;
`endif
                        end
                    end
                end
`ifdef SERIAL_PARITY_CHECK_EN
                st_chk: begin
                    if (accept) begin
                        // Received parity bit is compared, not folded in.
                        err_q <= in_bit ^ parity_q;
                        cnt_q <= cnt_inc;
                        state <= st_done;
                    end
                end
`endif
                st_done: begin
                    if (out_ready) begin
                        cnt_q <= 6'd0;
                        state <= st_idle;
`ifdef SERIAL_PARITY_CHECK_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity.sv
// tb_serial_parity: directed and lightly randomised checks of serial_parity
// with FRAME_LEN = 4, 8 and 7. Expected {err, parity} pairs are pushed when
// a frame is driven and popped when the DUT presents its result.
module tb_serial_parity;

    localparam int NDUT = 3;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_CHK  = 2'd2;

`ifdef SERIAL_PARITY_CHECK_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       clear      [NDUT];
    logic       in_valid   [NDUT];
    logic       in_bit     [NDUT];
    logic       in_ready   [NDUT];
    logic       out_valid  [NDUT];
    logic       out_parity [NDUT];
    logic       out_ready  [NDUT];
    logic       err        [NDUT];
    logic [5:0] bit_cnt    [NDUT];
    logic [1:0] state_dbg  [NDUT];

    logic [1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    serial_parity #(.FRAME_LEN(4)) u_len4 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]),
        .in_valid(in_valid[0]), .in_bit(in_bit[0]), .in_ready(in_ready[0]),
        .out_valid(out_valid[0]), .out_parity(out_parity[0]), .out_ready(out_ready[0]),
        .err(err[0]), .bit_cnt(bit_cnt[0]), .state_dbg(state_dbg[0])
    );

    serial_parity #(.FRAME_LEN(8)) u_len8 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]),
        .in_valid(in_valid[1]), .in_bit(in_bit[1]), .in_ready(in_ready[1]),
        .out_valid(out_valid[1]), .out_parity(out_parity[1]), .out_ready(out_ready[1]),
        .err(err[1]), .bit_cnt(bit_cnt[1]), .state_dbg(state_dbg[1])
    );

    serial_parity #(.FRAME_LEN(7)) u_len7 (
        .clk(clk), .rst_n(rst_n), .clear(clear[2]),
        .in_valid(in_valid[2]), .in_bit(in_bit[2]), .in_ready(in_ready[2]),
        .out_valid(out_valid[2]), .out_parity(out_parity[2]), .out_ready(out_ready[2]),
        .err(err[2]), .bit_cnt(bit_cnt[2]), .state_dbg(state_dbg[2])
    );

    // Clock: 10 time-unit period; inputs change and outputs are sampled on negedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit for one cycle; called and returns on a negedge.
    task automatic drive_bit(input int d, input logic b);
        in_valid[d] = 1'b1;
        in_bit[d]   = b;
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    // Send n data bits (bits[0] first) with 'gap' idle cycles between them.
    // In check builds a received-parity bit follows, inverted when flip=1.
    task automatic send_frame(input int d, input logic [31:0] bits, input int n,
                              input int gap, input logic flip, input string tag);
        logic p;
        logic e;
        p = 1'b0;
        e = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_bit(d, bits[i]);
            p = p ^ bits[i];
            check({tag, "_cnt"}, 32'(bit_cnt[d]), 32'(i + 1));
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check({tag, "_bubble_cnt"}, 32'(bit_cnt[d]), 32'(i + 1));
                    check({tag, "_bubble_state"}, 32'(state_dbg[d]), 32'(S_ACC));
                end
            end
        end
`ifdef SERIAL_PARITY_CHECK_EN
        check({tag, "_chk_state"}, 32'(state_dbg[d]), 32'(S_CHK));
        check({tag, "_chk_valid"}, 32'(out_valid[d]), 32'd0);
        check({tag, "_chk_ready"}, 32'(in_ready[d]), 32'd1);
        drive_bit(d, p ^ flip);
        e = flip;
`endif
        exp_q.push_back({e, p});
    endtask

    // Called right after send_frame: result must be visible this cycle,
    // held for 'hold' cycles, then taken while a stray bit is offered.
    task automatic expect_result(input int d, input int n, input int hold, input string tag);
        logic [1:0] exp;
        exp = 2'b00;
        check({tag, "_latency_valid"}, 32'(out_valid[d]), 32'd1);
        check({tag, "_done_cnt"}, 32'(bit_cnt[d]), 32'(n + EXTRA));
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_queue: observed=empty expected=entry", tag);
        end else begin
            exp = exp_q.pop_front();
        end
        check({tag, "_parity"}, 32'(out_parity[d]), 32'(exp[0]));
        check({tag, "_err"}, 32'(err[d]), 32'(exp[1]));
        for (int h = 0; h < hold; h++) begin
            out_ready[d] = 1'b0;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid[d]), 32'd1);
            check({tag, "_hold_parity"}, 32'(out_parity[d]), 32'(exp[0]));
            check({tag, "_hold_err"}, 32'(err[d]), 32'(exp[1]));
            check({tag, "_hold_ready"}, 32'(in_ready[d]), 32'd0);
        end
        check({tag, "_done_in_ready"}, 32'(in_ready[d]), 32'd0);
        out_ready[d] = 1'b1;
        in_valid[d]  = 1'b1;
        in_bit[d]    = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid[d]), 32'd0);
        check({tag, "_post_cnt"}, 32'(bit_cnt[d]), 32'd0);
        check({tag, "_post_state"}, 32'(state_dbg[d]), 32'(S_IDLE));
        check({tag, "_post_ready"}, 32'(in_ready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] rbits;
        int          rgap;
        int          rhold;

        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            clear[d]     = 1'b0;
            in_valid[d]  = 1'b0;
            in_bit[d]    = 1'b0;
            out_ready[d] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);

        // Reset state on every instance.
        for (int d = 0; d < NDUT; d++) begin
            check("rst_valid", 32'(out_valid[d]), 32'd0);
            check("rst_cnt", 32'(bit_cnt[d]), 32'd0);
            check("rst_parity", 32'(out_parity[d]), 32'd0);
            check("rst_err", 32'(err[d]), 32'd0);
            check("rst_ready", 32'(in_ready[d]), 32'd1);
            check("rst_state", 32'(state_dbg[d]), 32'(S_IDLE));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back 1,0,1,1.
        send_frame(0, 32'b1101, 4, 0, 1'b0, "b2b");
        expect_result(0, 4, 0, "b2b");

        // 0,1,1,0 with two bubbles between bits, consumer stalls 3 cycles.
        send_frame(0, 32'b0110, 4, 2, 1'b0, "bubble");
        expect_result(0, 4, 3, "bubble");

        // Clear alongside the third bit after two accepted bits.
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        in_valid[0] = 1'b1;
        in_bit[0]   = 1'b1;
        clear[0]    = 1'b1;
        @(negedge clk);
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        check("clr_cnt", 32'(bit_cnt[0]), 32'd0);
        check("clr_state", 32'(state_dbg[0]), 32'(S_IDLE));
        check("clr_parity", 32'(out_parity[0]), 32'd0);
        check("clr_ready", 32'(in_ready[0]), 32'd1);
        send_frame(0, 32'b0001, 4, 0, 1'b0, "after_clr");
        expect_result(0, 4, 1, "after_clr");

        // Clear together with out_ready while a result is pending.
        send_frame(0, 32'b0111, 4, 1, 1'b0, "clr_done");
        check("clr_done_valid_pre", 32'(out_valid[0]), 32'd1);
        void'(exp_q.pop_front());
        clear[0]     = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        clear[0]     = 1'b0;
        out_ready[0] = 1'b0;
        check("clr_done_valid", 32'(out_valid[0]), 32'd0);
        check("clr_done_cnt", 32'(bit_cnt[0]), 32'd0);
        check("clr_done_parity", 32'(out_parity[0]), 32'd0);
        check("clr_done_err", 32'(err[0]), 32'd0);

        // Asynchronous reset between edges while a result is waiting.
        send_frame(0, 32'b1011, 4, 0, 1'b0, "arst");
        check("arst_valid_pre", 32'(out_valid[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", 32'(out_valid[0]), 32'd0);
        check("arst_cnt", 32'(bit_cnt[0]), 32'd0);
        check("arst_parity", 32'(out_parity[0]), 32'd0);
        check("arst_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, 32'b0100, 4, 0, 1'b0, "post_arst");
        expect_result(0, 4, 0, "post_arst");

        // All-ones frames of even and odd length.
        send_frame(1, 32'hFF, 8, 0, 1'b0, "ones8");
        expect_result(1, 8, 0, "ones8");
        send_frame(2, 32'h7F, 7, 1, 1'b0, "ones7");
        expect_result(2, 7, 2, "ones7");

`ifdef SERIAL_PARITY_CHECK_EN
        // Data 1,1,1,0: matching check bit, then a wrong one.
        send_frame(0, 32'b0111, 4, 0, 1'b0, "chk_ok");
        expect_result(0, 4, 1, "chk_ok");
        send_frame(0, 32'b0111, 4, 0, 1'b1, "chk_bad");
        expect_result(0, 4, 1, "chk_bad");
`endif

        // A few random frames on the short instance.
        for (int k = 0; k < 6; k++) begin
            rbits = 32'($urandom_range(0, 15));
            rgap  = $urandom_range(0, 2);
            rhold = $urandom_range(0, 3);
            send_frame(0, rbits, 4, rgap, 1'b0, "rand");
            expect_result(0, 4, rhold, "rand");
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
